// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath.
// Weight and membrane widths are fixed here and used by every soma.
package snn_pkg;

    localparam int SNN_W = 8;
    localparam int SNN_V = 16;

    typedef logic signed [SNN_W-1:0] weight_t;
    typedef logic signed [SNN_V-1:0] vmem_t;

    typedef enum logic {
        ACTIVE,
        REFRACT
    } soma_state_e;

    // Add two wide operands and clamp the result into the vmem_t range.
    function automatic vmem_t sat_add(
        input logic signed [SNN_V+1:0] a,
        input logic signed [SNN_V+1:0] b
    );
        logic signed [SNN_V+1:0] s;
        s = a + b;
        if (s[SNN_V+1:SNN_V-1] == 3'b000 || s[SNN_V+1:SNN_V-1] == 3'b111)
            return s[SNN_V-1:0];
        if (s[SNN_V+1])
            return {1'b1, {(SNN_V-1){1'b0}}};
        return {1'b0, {(SNN_V-1){1'b1}}};
    endfunction

endpackage

// File: rtl/synapse_if.sv
// Per-synapse spike line driven by the synapse router.
// The soma only reads the spike member.
interface synapse_if;

    logic spike;

    modport src (output spike);
    modport dst (input spike);

endinterface

// File: rtl/weighted_sum.sv
// Combinational masked adder over the synaptic weights.
// Only synapses whose spike bit is set contribute.
module weighted_sum
    import snn_pkg::*;
#(
    parameter int S  = 8,
    parameter int SW = SNN_W + $clog2(S)
) (
    input  weight_t                 weight [S],
    input  logic    [S-1:0]         spike,
    output logic signed [SW-1:0]    sum
);

    always_comb begin
        sum = '0;
        for (int j = 0; j < S; j++) begin
            if (spike[j])
                sum = sum + SW'(weight[j]);
        end
    end

endmodule

// File: rtl/lif_soma.sv
// Leaky integrate-and-fire soma with refractory period.
// Define LIF_SOMA_LEAK_EN to apply the v >>> LEAK_SHIFT leak term.
module lif_soma
    import snn_pkg::*;
#(
    parameter int    S          = 8,
    parameter int    W          = SNN_W,
    parameter int    V          = SNN_V,
    parameter vmem_t THRESHOLD  = 16'sd100,
    parameter vmem_t V_RESET    = 16'sd0,
    parameter int    LEAK_SHIFT = 3,
    parameter int    REFRACTORY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    synapse_if.dst               dendrite [S-1:0],
    input  logic                 tick,
    input  logic                 wr_en,
    input  logic [$clog2(S)-1:0] wr_addr,
    input  weight_t              wr_data,
    output logic                 spike_out,
    output vmem_t                v_mem,
    output logic                 refractory
);

    localparam int SW = W + $clog2(S);
    localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    weight_t               wt [S];
    logic [S-1:0]          spk;
    logic signed [SW-1:0]  sum_c;
    logic signed [V:0]     s1_sum;
    logic                  s1_valid;

    soma_state_e           state, state_n;
    logic [RW-1:0]         rcnt, rcnt_n;
    logic signed [V+1:0]   base;
    vmem_t                 v_next, v_n;
    logic                  spike_n;

    for (genvar j = 0; j < S; j++) begin : g_spk
        assign spk[j] = dendrite[j].spike;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < S; j++)
                wt[j] <= '0;
        end else if (wr_en && 32'(wr_addr) < S) begin
            wt[wr_addr] <= wr_data;
        end
    end

    weighted_sum #(.S(S), .SW(SW)) u_sum (
        .weight (wt),
        .spike  (spk),
        .sum    (sum_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= tick;
            if (tick)
                s1_sum <= (V+1)'(sum_c);
        end
    end

    always_comb begin
`ifdef LIF_SOMA_LEAK_EN
        base = (V+2)'(v_mem) - ((V+2)'(v_mem) >>> LEAK_SHIFT);
`else
        base = (V+2)'(v_mem);
`endif
        v_next = sat_add(base, (V+2)'(s1_sum));
    end

    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        v_n     = v_mem;
        spike_n = 1'b0;
        if (s1_valid) begin
            unique case (state)
                ACTIVE: begin
                    if (v_next >= THRESHOLD) begin
                        spike_n = 1'b1;
                        v_n     = V_RESET;
                        rcnt_n  = RW'(REFRACTORY);
                        if (REFRACTORY != 0)
                            state_n = REFRACT;
                    end else begin
                        v_n = v_next;
                    end
                end
                REFRACT: begin
                    v_n    = V_RESET;
                    rcnt_n = rcnt - RW'(1);
                    if (rcnt == RW'(1))
                        state_n = ACTIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACTIVE;
            rcnt      <= '0;
            v_mem     <= '0;
            spike_out <= 1'b0;
        end else begin
            state     <= state_n;
            rcnt      <= rcnt_n;
            v_mem     <= v_n;
            spike_out <= spike_n;
        end
    end

    assign refractory = (state == REFRACT);

endmodule
